// File: rtl/byte_ram.sv
// Byte-addressable little-endian data RAM with 32-bit words, sized stores,
// sign/zero-extended loads, error responses and a fixed-latency response pipeline.
module byte_ram #(
    parameter int ADDR_WIDTH   = 32,
    parameter int RAM_SIZE     = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [1:0]            reqSize,
    input  logic                  reqUnsigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    output logic                  respValid,
    output logic                  respError,
    output logic [31:0]           readData
);

    localparam int IDX_W  = $clog2(RAM_SIZE);
    localparam int WIDX_W = ADDR_WIDTH - 2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic              accept;
    logic [WIDX_W-1:0] wordIdx;
    logic [IDX_W-1:0]  memIdx;
    logic [1:0]        lane;
    logic              outOfRange;
    logic              reqError;
    logic              doWrite;
    logic [3:0]        byteEn;
    logic [31:0]       laneData;
    logic [31:0]       rdWord;
    logic [7:0]        byteSel;
    logic [15:0]       halfSel;
    logic [31:0]       loadData;
    logic [31:0]       respDataIn;

    logic [31:0] mem [RAM_SIZE];

    logic [READ_LATENCY-1:0] pipeValid;
    logic [READ_LATENCY-1:0] pipeError;
    logic [31:0]             pipeData [READ_LATENCY];

    assign reqReady = !rst;
    assign accept   = reqValid && reqReady;

    assign wordIdx = address[ADDR_WIDTH-1:2];
    assign memIdx  = address[IDX_W+1:2];
    assign lane    = address[1:0];

    // The full word index is compared, so set upper address bits are caught
    // instead of aliasing onto a low word.
    assign outOfRange = (wordIdx >= WIDX_W'(RAM_SIZE));

    always_comb begin
        reqError = 1'b0;
        case (reqSize)
            SIZE_BYTE: reqError = 1'b0;
            SIZE_HALF: reqError = lane[0];
            SIZE_WORD: reqError = |lane;
            default:   reqError = 1'b1;
        endcase
        if (outOfRange) begin
            reqError = 1'b1;
        end
    end

    // Store data is replicated across lanes so the enables alone pick the target.
    always_comb begin
        byteEn   = 4'b0000;
        laneData = writeData;
        case (reqSize)
            SIZE_BYTE: begin
                byteEn   = 4'b0001 << lane;
                laneData = {4{writeData[7:0]}};
            end
            SIZE_HALF: begin
                byteEn   = lane[1] ? 4'b1100 : 4'b0011;
                laneData = {2{writeData[15:0]}};
            end
            SIZE_WORD: begin
                byteEn   = 4'b1111;
                laneData = writeData;
            end
            default: begin
                byteEn   = 4'b0000;
                laneData = writeData;
            end
        endcase
    end

    assign doWrite = accept && reqWrite && !reqError;

    always_ff @(posedge clk) begin
        if (doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[memIdx][8*i +: 8] <= laneData[8*i +: 8];
                end
            end
        end
    end

    // Read is combinational and captured at the accept edge, so a store one
    // cycle earlier is already visible to the following load.
    assign rdWord  = mem[memIdx];
    assign byteSel = rdWord[8*lane +: 8];
    assign halfSel = lane[1] ? rdWord[31:16] : rdWord[15:0];

    always_comb begin
        loadData = 32'h0;
        case (reqSize)
            SIZE_BYTE: loadData = {{24{!reqUnsigned && byteSel[7]}}, byteSel};
            SIZE_HALF: loadData = {{16{!reqUnsigned && halfSel[15]}}, halfSel};
            SIZE_WORD: loadData = rdWord;
            default:   loadData = 32'h0;
        endcase
    end

    assign respDataIn = (accept && !reqWrite && !reqError) ? loadData : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipeValid <= '0;
            pipeError <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipeData[i] <= 32'h0;
            end
        end else begin
            pipeValid[0] <= accept;
            pipeError[0] <= accept && reqError;
            pipeData[0]  <= respDataIn;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeError[i] <= pipeError[i-1];
                pipeData[i]  <= pipeData[i-1];
            end
        end
    end

    assign respValid = pipeValid[READ_LATENCY-1];
    assign respError = pipeError[READ_LATENCY-1];
    assign readData  = pipeData[READ_LATENCY-1];

endmodule

// File: tb/tb_byte_ram.sv
// Bench for byte_ram: two instances (latency 1 and 3) share one request stream
// and are checked against a byte-array reference model with cycle-exact responses.
module tb_byte_ram;

    localparam int RAM = 1024;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqUnsigned = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] writeData = 32'h0;

    logic        reqReady1, respValid1, respError1;
    logic [31:0] readData1;
    logic        reqReady3, respValid3, respError3;
    logic [31:0] readData3;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    armed = 1'b0;
    resp_t q1[$];
    resp_t q3[$];
    logic [7:0] mdl [4*RAM];

    byte_ram #(.ADDR_WIDTH(32), .RAM_SIZE(RAM), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady1),
        .reqWrite(reqWrite), .reqSize(reqSize), .reqUnsigned(reqUnsigned),
        .address(address), .writeData(writeData),
        .respValid(respValid1), .respError(respError1), .readData(readData1)
    );

    byte_ram #(.ADDR_WIDTH(32), .RAM_SIZE(RAM), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady3),
        .reqWrite(reqWrite), .reqSize(reqSize), .reqUnsigned(reqUnsigned),
        .address(address), .writeData(writeData),
        .respValid(respValid3), .respError(respError3), .readData(readData3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            bit e1, e3;
            e1 = (q1.size() > 0) && (q1[0].due == cyc);
            chk("L1 respValid", 32'(respValid1), 32'(e1));
            if (e1) begin
                chk("L1 respError", 32'(respError1), 32'(q1[0].err));
                chk("L1 readData", readData1, q1[0].data);
                void'(q1.pop_front());
            end
            e3 = (q3.size() > 0) && (q3[0].due == cyc);
            chk("L3 respValid", 32'(respValid3), 32'(e3));
            if (e3) begin
                chk("L3 respError", 32'(respError3), 32'(q3[0].err));
                chk("L3 readData", readData3, q3[0].data);
                void'(q3.pop_front());
            end
        end
    end

    // Reference: plain byte array, size in bytes, alignment by modulo.
    task automatic issue(input bit wr, input bit [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int          n;
        bit          err;
        logic [31:0] val;
        resp_t       r;
        reqValid    = 1'b1;
        reqWrite    = wr;
        reqSize     = sz;
        reqUnsigned = uns;
        address     = addr;
        writeData   = wd;
        n   = 1 << sz;
        err = (sz == 2'd3) || ((addr % n) != 0) || (addr >= 32'(4*RAM));
        val = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < n; i++) mdl[addr + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) val[8*i +: 8] = mdl[addr + i];
                if (!uns && n == 1 && val[7])  val[31:8]  = '1;
                if (!uns && n == 2 && val[15]) val[31:16] = '1;
            end
        end
        r.err  = err;
        r.data = val;
        r.due  = cyc + 1;
        q1.push_back(r);
        r.due  = cyc + 3;
        q3.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        reqValid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        armed = 1'b1;
        chk("reqReady1 in reset", 32'(reqReady1), 32'd0);
        chk("reqReady3 in reset", 32'(reqReady3), 32'd0);
        chk("L1 respError reset", 32'(respError1), 32'd0);
        chk("L1 readData reset", readData1, 32'd0);
        chk("L3 respError reset", 32'(respError3), 32'd0);
        chk("L3 readData reset", readData3, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reqReady1 run", 32'(reqReady1), 32'd1);
        chk("reqReady3 run", 32'(reqReady3), 32'd1);

        // word store then load, byte/half stores with extension
        issue(1, 2, 0, 32'h10, 32'hDEADBEEF);
        issue(0, 2, 0, 32'h10, 32'h0);
        issue(1, 0, 0, 32'h13, 32'h00000080);
        issue(0, 0, 0, 32'h13, 32'h0);
        issue(0, 0, 1, 32'h13, 32'h0);
        issue(0, 2, 0, 32'h10, 32'h0);
        issue(1, 1, 0, 32'h12, 32'h00001234);
        issue(0, 1, 0, 32'h12, 32'h0);
        issue(0, 1, 1, 32'h10, 32'h0);
        issue(0, 2, 1, 32'h10, 32'h0);
        idle(2);

        // error cases
        issue(0, 1, 0, 32'h11, 32'h0);
        issue(1, 2, 0, 32'h12, 32'h11111111);
        issue(0, 2, 0, 32'h10, 32'h0);
        issue(0, 3, 0, 32'h10, 32'h0);
        issue(0, 2, 0, 32'(4*RAM), 32'h0);
        issue(1, 2, 0, 32'(4*RAM), 32'h22222222);
        issue(0, 0, 0, 32'h80000010, 32'h0);
        issue(1, 0, 0, 32'h40000013, 32'h55);
        issue(0, 2, 0, 32'h10, 32'h0);
        idle(4);

        // continuous traffic through the deeper pipeline
        issue(1, 2, 0, 32'h20, 32'hCAFEF00D);
        issue(0, 2, 0, 32'h20, 32'h0);
        issue(0, 2, 0, 32'h10, 32'h0);
        issue(1, 0, 0, 32'h21, 32'h000000A5);
        issue(0, 2, 0, 32'h20, 32'h0);
        idle(4);

        // reset with loads in flight; store presented during reset is ignored
        issue(0, 2, 0, 32'h10, 32'h0);
        issue(0, 2, 0, 32'h20, 32'h0);
        rst       = 1'b1;
        reqValid  = 1'b1;
        reqWrite  = 1'b1;
        reqSize   = 2'b10;
        address   = 32'h10;
        writeData = 32'h0BADF00D;
        while (q1.size() > 0 && q1[q1.size()-1].due > cyc) void'(q1.pop_back());
        while (q3.size() > 0 && q3[q3.size()-1].due > cyc) void'(q3.pop_back());
        #1;
        chk("reqReady1 mid reset", 32'(reqReady1), 32'd0);
        chk("reqReady3 mid reset", 32'(reqReady3), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        reqValid = 1'b0;
        idle(3);
        issue(0, 2, 0, 32'h10, 32'h0);
        issue(0, 1, 1, 32'h22, 32'h0);
        idle(4);

        // initialise a window, then randomized traffic inside and around it
        for (int w = 0; w < 32; w++) issue(1, 2, 0, 32'(w*4), $urandom);
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = 32'(4*RAM) + 32'($urandom_range(0, 255));
                1:       a = 32'h1 << $urandom_range(12, 31);
                default: a = 32'($urandom_range(0, 127));
            endcase
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
        end
        idle(6);
        chk("L1 drain", 32'(q1.size()), 32'd0);
        chk("L3 drain", 32'(q3.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
